// File: rtl/traffic_ctrl.sv
// traffic_ctrl: two-road traffic light controller with sensor requests, green extension and flash mode
module traffic_ctrl #(
  parameter int TICK_DIV     = 1000,
  parameter int MIN_GREEN    = 5,
  parameter int MAX_GREEN    = 20,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car1,
  input  logic       car2,
  input  logic       flash,
  output logic       G1,
  output logic       Y1,
  output logic       R1,
  output logic       G2,
  output logic       Y2,
  output logic       R2,
  output logic       d,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {AR1, GRN1, YEL1, AR2, GRN2, YEL2, FLASH} state_t;
  localparam int TOP = MAX_GREEN > YELLOW_TICKS ? (MAX_GREEN > ALLRED_TICKS ? MAX_GREEN : ALLRED_TICKS)
                                                 : (YELLOW_TICKS > ALLRED_TICKS ? YELLOW_TICKS : ALLRED_TICKS);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(TOP + 1);
  localparam logic [PW-1:0] P_END = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] C_MIN = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] C_MAX = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] C_YEL = CW'(YELLOW_TICKS - 1);
  localparam logic [CW-1:0] C_AR  = CW'(ALLRED_TICKS - 1);
  localparam logic [CW-1:0] C_TOP = CW'(TOP);
  state_t state, nxt;
  logic [PW-1:0] presc;
  logic [CW-1:0] cnt;
  logic pend1, pend2, blink, tick;
  assign tick = presc == P_END;
  always_comb begin
    nxt = state;
    case (state)
      AR1:     nxt = tick && cnt >= C_AR ? GRN1 : AR1;
      GRN1:    nxt = tick && pend2 && (cnt >= C_MAX || (cnt >= C_MIN && !car1)) ? YEL1 : GRN1;
      YEL1:    nxt = tick && cnt >= C_YEL ? AR2 : YEL1;
      AR2:     nxt = tick && cnt >= C_AR ? GRN2 : AR2;
      GRN2:    nxt = tick && pend1 && (cnt >= C_MAX || (cnt >= C_MIN && !car2)) ? YEL2 : GRN2;
      YEL2:    nxt = tick && cnt >= C_YEL ? AR1 : YEL2;
      default: nxt = AR1;
    endcase
    if (flash) nxt = FLASH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= AR1;
      presc <= '0;
      cnt   <= '0;
      pend1 <= 1'b0;
      pend2 <= 1'b0;
      blink <= 1'b0;
      d     <= 1'b1;
    end else begin
      state <= nxt;
      presc <= nxt != state || tick ? '0 : presc + 1'b1;
      cnt   <= nxt != state ? '0 : tick && cnt != C_TOP ? cnt + 1'b1 : cnt;
      pend1 <= state != GRN1 && (nxt == GRN1 ? 1'b0 : car1 | pend1);
      pend2 <= state != GRN2 && (nxt == GRN2 ? 1'b0 : car2 | pend2);
      blink <= state == FLASH && nxt == FLASH && (blink ^ tick);
      d     <= nxt == FLASH ? d : nxt inside {AR1, GRN1, YEL1};
    end
  end
  assign G1    = state == GRN1;
  assign Y1    = state == YEL1 || (state == FLASH && blink);
  assign R1    = state inside {AR1, AR2, GRN2, YEL2};
  assign G2    = state == GRN2;
  assign Y2    = state == YEL2 || (state == FLASH && blink);
  assign R2    = state inside {AR1, GRN1, YEL1, AR2};
  assign phase = state;
endmodule

// File: tb/tb_traffic_ctrl.sv
// tb_traffic_ctrl: scoreboard bench comparing two differently-prescaled controllers against a phase/elapsed-time model
module tb_traffic_ctrl;
  localparam int MINV = 3, MAXV = 6, YELV = 2, ARV = 1;
  logic clk = 0, rst, car1, car2, flash;
  logic a_g1, a_y1, a_r1, a_g2, a_y2, a_r2, a_d, b_g1, b_y1, b_r1, b_g2, b_y2, b_r2, b_d;
  logic [2:0] a_ph, b_ph;
  int tests = 0, fails = 0;
  int ph[2], n[2];
  bit p1[2], p2[2], md[2];
  logic [9:0] q0[$], q1[$];
  always #5 clk = ~clk;
  traffic_ctrl #(.TICK_DIV(1), .MIN_GREEN(MINV), .MAX_GREEN(MAXV), .YELLOW_TICKS(YELV), .ALLRED_TICKS(ARV)) dut_a (
    .clk(clk), .rst(rst), .car1(car1), .car2(car2), .flash(flash),
    .G1(a_g1), .Y1(a_y1), .R1(a_r1), .G2(a_g2), .Y2(a_y2), .R2(a_r2), .d(a_d), .phase(a_ph));
  traffic_ctrl #(.TICK_DIV(4), .MIN_GREEN(MINV), .MAX_GREEN(MAXV), .YELLOW_TICKS(YELV), .ALLRED_TICKS(ARV)) dut_b (
    .clk(clk), .rst(rst), .car1(car1), .car2(car2), .flash(flash),
    .G1(b_g1), .Y1(b_y1), .R1(b_r1), .G2(b_g2), .Y2(b_y2), .R2(b_r2), .d(b_d), .phase(b_ph));
  function automatic logic [9:0] exp_out(int i, int td);
    int p = ph[i];
    bit b = p == 6 && (n[i] / td) % 2 == 1;
    return {p == 1, p == 2 || b, p == 0 || (p >= 3 && p <= 5), p == 4, p == 5 || b, p <= 3, md[i], 3'(p)};
  endfunction
  task automatic model(input int i, input int td, input logic r, c1, c2, f);
    int k = (n[i] + 1) / td;
    bit tk = (n[i] + 1) % td == 0;
    int np = ph[i];
    if (r) begin
      ph[i] = 0; n[i] = 0; p1[i] = 0; p2[i] = 0; md[i] = 1;
      return;
    end
    if (f) np = 6;
    else if (np == 6) np = 0;
    else if (tk)
      case (ph[i])
        0: if (k >= ARV) np = 1;
        1: if (p2[i] && (k >= MAXV || (k >= MINV && !c1))) np = 2;
        2: if (k >= YELV) np = 3;
        3: if (k >= ARV) np = 4;
        4: if (p1[i] && (k >= MAXV || (k >= MINV && !c2))) np = 5;
        5: if (k >= YELV) np = 0;
        default: np = 0;
      endcase
    if (ph[i] != 1) p1[i] = np == 1 ? 1'b0 : p1[i] | c1;
    if (ph[i] != 4) p2[i] = np == 4 ? 1'b0 : p2[i] | c2;
    if (np != 6) md[i] = np < 3;
    n[i] = np == ph[i] ? n[i] + 1 : 0;
    ph[i] = np;
  endtask
  task automatic run(input logic r, c1, c2, f, input int cycles);
    for (int j = 0; j < cycles; j++) begin
      rst = r; car1 = c1; car2 = c2; flash = f;
      @(posedge clk);
      model(0, 1, r, c1, c2, f);
      model(1, 4, r, c1, c2, f);
      q0.push_back(exp_out(0, 1));
      q1.push_back(exp_out(1, 4));
      #1;
    end
  endtask
  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got G1Y1R1G2Y2R2_d_phase=%b required %b", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q0.size() > 0) check("div1", {a_g1, a_y1, a_r1, a_g2, a_y2, a_r2, a_d, a_ph}, q0.pop_front());
    if (q1.size() > 0) check("div4", {b_g1, b_y1, b_r1, b_g2, b_y2, b_r2, b_d, b_ph}, q1.pop_front());
  end
  initial begin
    int fl = 0;
    logic r, c1, c2, f;
    run(1, 0, 0, 0, 2);
    run(0, 0, 0, 0, 100);
    run(0, 0, 1, 0, 1);
    run(0, 0, 0, 0, 40);
    run(0, 1, 0, 0, 1);
    run(0, 0, 0, 0, 60);
    run(0, 1, 1, 0, 1);
    run(0, 1, 0, 0, 80);
    run(0, 0, 1, 0, 1);
    run(0, 0, 0, 0, 11);
    run(1, 0, 0, 0, 1);
    run(0, 0, 0, 0, 10);
    run(0, 0, 0, 1, 20);
    run(0, 0, 0, 0, 5);
    run(1, 0, 0, 1, 2);
    run(0, 0, 0, 0, 10);
    for (int j = 0; j < 4000; j++) begin
      if (fl == 0 && $urandom_range(0, 399) == 0) fl = $urandom_range(1, 30);
      f  = fl > 0;
      fl = fl > 0 ? fl - 1 : 0;
      r  = $urandom_range(0, 599) == 0;
      c1 = $urandom_range(0, 9) < 2;
      c2 = $urandom_range(0, 9) < 2;
      run(r, c1, c2, f, 1);
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
